// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I opcode constants and sequencer state type
package rv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } mc_state_t;

  // True for every base-ISA major opcode this core executes.
  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I_ALU, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: opc_legal = 1'b1;
      default:                               opc_legal = 1'b0;
    endcase
  endfunction

  // Loads and stores are the only instructions that visit MEM.
  function automatic logic opc_is_mem(input logic [6:0] opc);
    opc_is_mem = (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - counts handshake wait cycles and flags the final allowed wait
module mc_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int TMR_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count;

  // expired marks the TIMEOUT-th consecutive wait cycle, i.e. the one that traps.
  assign expired = inc && (count == LAST);

  // Wait counter: restarts whenever the sequencer is outside a handshake state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with traps
module mc_sequencer
  import rv_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15,
  parameter int TMR_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             cu_RUWr,
  input  logic             cu_DmWr,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ru_we,
  output logic             pc_en,
  output logic             busy,
  output logic             illegal,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instret
);

  mc_state_t state, state_next;
  logic      tmr_clr, tmr_inc, tmr_expired;

  // The timer only runs while a request is outstanding; any other state resets it,
  // so it is always fresh on entry to FETCH or MEM.
  assign tmr_clr = !((state == FETCH) || (state == MEM));
  assign tmr_inc = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);
  assign busy    = (state != IDLE) && (state != TRAP);

  mc_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expired(tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and single-cycle strobes, all decoded from the current state.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ir_en      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ru_we      = 1'b0;
    pc_en      = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en      = 1'b1;
          state_next = DECODE;
        end else if (tmr_expired) begin
          state_next = TRAP;
        end
      end
      DECODE: begin
        state_next = opc_legal(opcode) ? EXEC : TRAP;
      end
      EXEC: begin
        state_next = opc_is_mem(opcode) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cu_DmWr;
        if (dmem_ready) begin
          state_next = WB;
        end else if (tmr_expired) begin
          state_next = TRAP;
        end
      end
      WB: begin
        ru_we      = cu_RUWr;
        pc_en      = 1'b1;
        state_next = run ? FETCH : IDLE;
      end
      TRAP: begin
        state_next = TRAP;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Retired-instruction counter and sticky trap causes; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret     <= '0;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (pc_en) instret <= instret + 1'b1;
      if ((state == DECODE) && !opc_legal(opcode)) illegal <= 1'b1;
      if (tmr_expired) timeout_err <= 1'b1;
    end
  end

endmodule
